// File: rtl/periph_timer_pkg.sv
// Shared register map, TCON layout and address decode for the peripheral timer block.
package periph_timer_pkg;

  localparam int unsigned BUS_W    = 32;
  localparam int unsigned LED_W    = 8;
  localparam int unsigned SWITCH_W = 8;
  localparam int unsigned DIGI_W   = 12;
  localparam int unsigned TCON_W   = 3;

  localparam logic [BUS_W-1:0] ADDR_TH      = 32'h4000_0000;
  localparam logic [BUS_W-1:0] ADDR_TL      = 32'h4000_0004;
  localparam logic [BUS_W-1:0] ADDR_TCON    = 32'h4000_0008;
  localparam logic [BUS_W-1:0] ADDR_LED     = 32'h4000_000C;
  localparam logic [BUS_W-1:0] ADDR_SWITCH  = 32'h4000_0010;
  localparam logic [BUS_W-1:0] ADDR_DIGI    = 32'h4000_0014;
  localparam logic [BUS_W-1:0] ADDR_SYSTICK = 32'h4000_0018;

  localparam int unsigned TCON_EN_BIT = 0;
  localparam int unsigned TCON_IE_BIT = 1;
  localparam int unsigned TCON_IS_BIT = 2;

  // Field order mirrors the TCON bit indices above (is = bit 2, en = bit 0).
  typedef struct packed {
    logic is;
    logic ie;
    logic en;
  } tcon_t;

  typedef enum logic [2:0] {
    SEL_TH,
    SEL_TL,
    SEL_TCON,
    SEL_LED,
    SEL_SWITCH,
    SEL_DIGI,
    SEL_SYSTICK,
    SEL_NONE
  } reg_sel_t;

  // Word-aligned decode; the byte offset within a word is ignored.
  function automatic reg_sel_t decode(input logic [BUS_W-1:0] addr);
    logic [BUS_W-1:0] word;
    word = {addr[BUS_W-1:2], 2'b00};
    case (word)
      ADDR_TH:      return SEL_TH;
      ADDR_TL:      return SEL_TL;
      ADDR_TCON:    return SEL_TCON;
      ADDR_LED:     return SEL_LED;
      ADDR_SWITCH:  return SEL_SWITCH;
      ADDR_DIGI:    return SEL_DIGI;
      ADDR_SYSTICK: return SEL_SYSTICK;
      default:      return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/periph_timer_core.sv
// Reloading up-counter: TH reload value, TL count, TCON enable / interrupt enable / status.
module periph_timer_core
  import periph_timer_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_th,
  input  logic               wr_tl,
  input  logic               wr_tcon,
  input  logic [BUS_W-1:0]   wdata,
  output logic [TIMER_W-1:0] th,
  output logic [TIMER_W-1:0] tl,
  output tcon_t              tcon
);

  logic               reload;
  logic [TIMER_W-1:0] tl_next;
  tcon_t              tcon_next;

  // CPU writes take priority over reload and status set in the same cycle.
  always_comb begin
    reload    = tcon.en && (tl == '1);
    tl_next   = tl;
    tcon_next = tcon;

    if (wr_tl) begin
      tl_next = TIMER_W'(wdata);
    end else if (reload) begin
      tl_next = th;
    end else if (tcon.en) begin
      tl_next = tl + TIMER_W'(1);
    end

    if (wr_tcon) begin
      tcon_next.en = wdata[TCON_EN_BIT];
      tcon_next.ie = wdata[TCON_IE_BIT];
      // Software may only clear status, never set it.
      tcon_next.is = tcon.is & wdata[TCON_IS_BIT];
    end else if (reload && tcon.ie) begin
      tcon_next.is = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th   <= '0;
      tl   <= '0;
      tcon <= '0;
    end else begin
      if (wr_th) begin
        th <= TIMER_W'(wdata);
      end
      tl   <= tl_next;
      tcon <= tcon_next;
    end
  end

endmodule

// File: rtl/periph_timer.sv
// Memory-mapped peripheral: timer core plus LED, 7-segment, switch input and systick.
module periph_timer
  import periph_timer_pkg::*;
#(
  parameter int unsigned TIMER_W = 32
) (
  input  logic                reset,
  input  logic                clk,
  input  logic                rd,
  input  logic                wr,
  input  logic [BUS_W-1:0]    addr,
  input  logic [BUS_W-1:0]    wdata,
  output logic [BUS_W-1:0]    rdata,
  output logic [LED_W-1:0]    led,
  input  logic [SWITCH_W-1:0] switch,
  output logic [DIGI_W-1:0]   digi,
  output logic                irq,
  input  logic                kernel
);

  reg_sel_t            sel;
  logic [TIMER_W-1:0]  th;
  logic [TIMER_W-1:0]  tl;
  tcon_t               tcon;
  logic [TIMER_W-1:0]  systick;
  logic [SWITCH_W-1:0] switch_meta;
  logic [SWITCH_W-1:0] switch_sync;

  assign sel = decode(addr);

  periph_timer_core #(
    .TIMER_W (TIMER_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .wr_th   (wr && (sel == SEL_TH)),
    .wr_tl   (wr && (sel == SEL_TL)),
    .wr_tcon (wr && (sel == SEL_TCON)),
    .wdata   (wdata),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon)
  );

  // Interrupts are masked while executing in kernel mode.
  assign irq = tcon.ie & tcon.is & ~kernel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led         <= '0;
      digi        <= '0;
      systick     <= '0;
      switch_meta <= '0;
      switch_sync <= '0;
    end else begin
      if (wr && (sel == SEL_LED)) begin
        led <= wdata[LED_W-1:0];
      end
      if (wr && (sel == SEL_DIGI)) begin
        digi <= wdata[DIGI_W-1:0];
      end
      systick     <= systick + TIMER_W'(1);
      switch_meta <= switch;
      switch_sync <= switch_meta;
    end
  end

  // Combinational read mux, zero-extended, quiet when not reading.
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (sel)
        SEL_TH:      rdata = BUS_W'(th);
        SEL_TL:      rdata = BUS_W'(tl);
        SEL_TCON:    rdata = BUS_W'(tcon);
        SEL_LED:     rdata = BUS_W'(led);
        SEL_SWITCH:  rdata = BUS_W'(switch_sync);
        SEL_DIGI:    rdata = BUS_W'(digi);
        SEL_SYSTICK: rdata = BUS_W'(systick);
        default:     rdata = '0;
      endcase
    end
  end

endmodule
